// File: rtl/vote_tally.sv
`default_nettype none
// ============================================================================
// Module      : vote_tally
// Description : Ballot-casting stage downstream of password verification.
//               A rising edge on the access grant opens a single-ballot
//               window. One legal selection per window is counted. Closing
//               the poll starts a one-candidate-per-cycle scan that reports
//               the winner and a tie flag.
// Ports       : clk, rst (sync, active-low)
//               access        - grant level; rising edge opens a ballot
//               vote_valid    - selection presented this cycle
//               vote_sel      - candidate index
//               close_poll    - ends polling (sticky until reset)
//               vote_ready    - ballot window open
//               vote_ack      - pulse: vote counted
//               vote_reject   - pulse: illegal selection, ballot spoiled
//               vote_timeout  - pulse: window expired unused
//               rd_sel        - readout select
//               rd_count      - count[rd_sel], 0 when out of range
//               total_votes   - saturating sum of accepted votes
//               poll_closed   - close_poll accepted
//               result_valid  - winner/tie final
//               winner        - lowest index holding the maximum count
//               tie           - maximum shared by two or more candidates
// Revision    : 1.0 - initial release
// ============================================================================
module vote_tally #(
    parameter int NUM_CAND = 4,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             access,
    input  logic             vote_valid,
    input  logic [SEL_W-1:0] vote_sel,
    input  logic             close_poll,
    output logic             vote_ready,
    output logic             vote_ack,
    output logic             vote_reject,
    output logic             vote_timeout,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] total_votes,
    output logic             poll_closed,
    output logic             result_valid,
    output logic [SEL_W-1:0] winner,
    output logic             tie
);

    // The window timer only has to reach TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [SEL_W:0]   c_NUM_CAND = (SEL_W+1)'(NUM_CAND);
    localparam logic [SEL_W-1:0] c_LAST_IDX = SEL_W'(NUM_CAND - 1);
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_access_q;
    logic [TMR_W-1:0]    r_timer;
    logic [CNT_W-1:0]    r_count [NUM_CAND];
    logic [CNT_W-1:0]    r_total;
    logic                r_ack;
    logic                r_reject;
    logic                r_timeout;
    logic [SEL_W-1:0]    r_scan_idx;
    logic [CNT_W-1:0]    r_best;
    logic [SEL_W-1:0]    r_winner;
    logic                r_tie;

    logic                w_acc_rise;
    logic                w_sel_legal;
    logic                w_inc;
    logic                w_ack_nxt;
    logic                w_reject_nxt;
    logic                w_timeout_nxt;
    logic [CNT_W-1:0]    w_scan_cnt;
    logic [CNT_W-1:0]    w_rd_cnt;

    assign w_acc_rise  = access & ~r_access_q;
    // Zero-extend the select so illegal codes above NUM_CAND-1 compare cleanly.
    assign w_sel_legal = ({1'b0, vote_sel} < c_NUM_CAND);

    // ------------------------------------------------------------------
    // Next-state and pulse decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_inc         = 1'b0;
        w_ack_nxt     = 1'b0;
        w_reject_nxt  = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (close_poll) begin
                    w_state_nxt = ST_SCAN;
                end else if (w_acc_rise) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vote_valid) begin
                    // A vote in the last window cycle beats the timeout.
                    if (w_sel_legal) begin
                        w_inc     = 1'b1;
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end else if (close_poll) begin
                    // Closing takes the unused window; no timeout is reported.
                    w_state_nxt = ST_SCAN;
                end else if (r_timer == c_TMR_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
                // A vote arriving with close_poll is still processed above.
                if (close_poll) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_scan_idx == c_LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Count multiplexers (scan compare and external readout)
    // ------------------------------------------------------------------
    always_comb begin
        w_scan_cnt = '0;
        w_rd_cnt   = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (r_scan_idx == SEL_W'(i)) begin
                w_scan_cnt = r_count[i];
            end
            if (rd_sel == SEL_W'(i)) begin
                w_rd_cnt = r_count[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // State, timer and edge register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_access_q <= 1'b0;
            r_timer    <= '0;
            r_scan_idx <= '0;
            r_ack      <= 1'b0;
            r_reject   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_access_q <= access;
            r_ack      <= w_ack_nxt;
            r_reject   <= w_reject_nxt;
            r_timeout  <= w_timeout_nxt;
            // Timer counts ARMED cycles; held at zero elsewhere so every
            // new window starts from zero.
            if (r_state == ST_ARMED) begin
                r_timer <= r_timer + TMR_W'(1);
            end else begin
                r_timer <= '0;
            end
            if (r_state == ST_SCAN) begin
                r_scan_idx <= r_scan_idx + SEL_W'(1);
            end else begin
                r_scan_idx <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-candidate and total counters (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                r_count[i] <= '0;
            end
            r_total <= '0;
        end else if (w_inc) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if ((vote_sel == SEL_W'(i)) && (r_count[i] != c_CNT_MAX)) begin
                    r_count[i] <= r_count[i] + CNT_W'(1);
                end
            end
            if (r_total != c_CNT_MAX) begin
                r_total <= r_total + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Winner scan: index 0 seeds the running best, later indices replace
    // it only when strictly greater, so the lowest index wins on equality.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_best   <= '0;
            r_winner <= '0;
            r_tie    <= 1'b0;
        end else if (r_state == ST_SCAN) begin
            if (r_scan_idx == '0) begin
                r_best   <= w_scan_cnt;
                r_winner <= '0;
                r_tie    <= 1'b0;
            end else if (w_scan_cnt > r_best) begin
                r_best   <= w_scan_cnt;
                r_winner <= r_scan_idx;
                r_tie    <= 1'b0;
            end else if (w_scan_cnt == r_best) begin
                r_tie <= 1'b1;
            end
        end
    end

    assign vote_ready   = (r_state == ST_ARMED);
    assign vote_ack     = r_ack;
    assign vote_reject  = r_reject;
    assign vote_timeout = r_timeout;
    assign rd_count     = w_rd_cnt;
    assign total_votes  = r_total;
    assign poll_closed  = (r_state == ST_SCAN) || (r_state == ST_DONE);
    assign result_valid = (r_state == ST_DONE);
    assign winner       = r_winner;
    assign tie          = r_tie;

endmodule
`default_nettype wire
